// File: rtl/i2s_tx.sv
// I2S serial transmitter: shifts a stereo pair MSB first on each bit-clock falling strobe,
// with word select leading the data by one slot, fed from a single-entry holding register.
module i2s_tx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck_fall,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sd,
    output logic             ws,
    output logic             frame_start,
    output logic             underrun
);

    localparam int SLOTS = 2 * WIDTH;
    localparam int CW    = $clog2(SLOTS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
    localparam logic [CW-1:0] RIGHT_SLOT = CW'(WIDTH);

    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic [SLOTS-1:0] shift_q, shift_d;
    logic [SLOTS-1:0] hold_q, hold_d;
    logic             ready_q, ready_d;
    logic             sd_q, sd_d;
    logic             ws_q, ws_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic             load;
    logic             accept;

    always_comb begin
        load          = sck_fall && (bcnt_q == LAST_SLOT);
        accept        = in_valid && ready_q;
        bcnt_d        = bcnt_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        ready_d       = ready_q;
        sd_d          = sd_q;
        ws_d          = ws_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        // After 2W-1 left shifts the previous frame's R[0] sits in the MSB,
        // so the MSB is always the next bit out, including on the load slot.
        if (sck_fall) begin
            sd_d = shift_q[SLOTS-1];
            if (load) begin
                bcnt_d        = '0;
                shift_d       = ready_q ? '0 : hold_q;
                frame_start_d = 1'b1;
                underrun_d    = ready_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                shift_d = {shift_q[SLOTS-2:0], 1'b0};
            end
            ws_d = (bcnt_d >= RIGHT_SLOT);
        end

        // Load frees the holding register only when it was full; accept only
        // happens when empty, so the two never collide.
        if (load && !ready_q) begin
            ready_d = 1'b1;
        end
        if (accept) begin
            ready_d = 1'b0;
            hold_d  = {in_left, in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt_q        <= LAST_SLOT;
            shift_q       <= '0;
            hold_q        <= '0;
            ready_q       <= 1'b1;
            sd_q          <= 1'b0;
            ws_q          <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            ready_q       <= ready_d;
            sd_q          <= sd_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign in_ready    = ready_q;
    assign sd          = sd_q;
    assign ws          = ws_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio transmitter for the mixer output path. It sits directly downstream of the clock divider and consumes its one-cycle falling-edge strobe as the bit-clock tick. On each tick it shifts out a stereo sample pair as standard I2S: MSB first, word select leading the data by one bit. Parallel sample pairs arrive from the mixer core over a valid/ready handshake into a single-entry holding register.

## Interface
- WIDTH, 16: bits per channel sample. A frame is 2*WIDTH bit slots.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- sck_fall  in  1  bit-clock falling-edge strobe from the clock divider; one clk wide per bit slot.
- in_left  in  WIDTH  left sample, two's complement.
- in_right  in  WIDTH  right sample, two's complement.
- in_valid  in  1  sample pair present.
- in_ready  out  1  holding register empty; the pair is accepted when in_valid && in_ready at posedge.
- sd  out  1  serial data.
- ws  out  1  word select: 0 = left, 1 = right.
- frame_start  out  1  one-clk pulse when slot 0 is entered.
- underrun  out  1  one-clk pulse when a frame loads with no pending sample.

## Operation
- Slot counter bcnt runs 0..2W-1, where W = WIDTH. It advances by one (mod 2W) on every clk cycle with sck_fall=1.
  - No edge detection: if sck_fall is high for N consecutive cycles, bcnt advances N times.
- Frame word F = {L, R}, 2W bits, sent MSB first and delayed one slot.
  - Slot 0: sd = previous frame's R[0].
  - Slots 1..W: sd = L[W-1]..L[0].
  - Slots W+1..2W-1: sd = R[W-1]..R[1].
  - R[0] goes out in slot 0 of the next frame.
- ws = 0 in slots 0..W-1 and 1 in slots W..2W-1, so ws changes one slot before the MSB of its channel.
- Load: on the sck_fall that takes bcnt from 2W-1 to 0:
  - If the holding register is full, its pair moves to the shift register and the holding register becomes empty.
  - If it is empty, the shift register loads zeros and underrun pulses.
  - On the same edge, sd takes the old shift register's R[0].
- Holding register:
  - in_ready = !full.
  - Accepting a pair sets full.
  - There is no bypass: a pair accepted in the same cycle as a load goes into the holding register and is used by the following frame. The load sees the holding state from before that edge.
  - A load and an accept in the same cycle leave full = 1.
- All outputs are registered.

## Timing
- Reset (rst=0 at posedge) sets:
  - bcnt = 2W-1, ws = 1, sd = 0.
  - Shift register = 0, holding empty (in_ready = 1).
  - frame_start = 0, underrun = 0.
- Reset mid-frame aborts the frame immediately and drops any pending sample. Reset has priority over sck_fall and over in_valid in the same cycle.
- The first sck_fall after reset enters slot 0 and performs a load. A pair pushed before that strobe plays in the first frame.
- sd and ws update in the clk cycle following the posedge that sampled sck_fall=1, and hold stable until the next strobe.
  - This meets I2S setup for a receiver sampling on the bit-clock rising edge.
- frame_start and underrun are high for exactly the one clk cycle after the load edge.
- in_ready drops in the cycle after acceptance and rises in the cycle after a load that empties the holding register.
- Throughput: one pair per 2W sck_fall strobes. in_valid held high never loses or duplicates a pair.

## Test plan
All scenarios use WIDTH=4 (8 slots) and sck_fall pulsing every 4 clk.
- Reset, then push L=0xA, R=0x5 before the first strobe:
  - Slots 0..7: sd = 0,1,0,1,0,0,1,0 and ws = 0,0,0,0,1,1,1,1.
  - The next slot 0 has sd = 1.
  - frame_start pulses at each slot 0; underrun stays 0.
- No push after reset:
  - underrun pulses at the first slot 0; sd stays 0 for the whole frame.
- Continuous in_valid with pairs (0x1,0x2), (0x3,0x4), (0x5,0x6):
  - Frames carry the pairs in order.
  - in_ready is low from acceptance until the next load.
  - No underrun.
- Push asserted in the same cycle as the load edge with the holding register empty:
  - The current frame is zeros and underrun pulses.
  - The pushed pair plays in the next frame.
- rst low at slot 3 of a frame with a pair pending:
  - All outputs return to reset values and the pending pair is dropped.
  - The next strobe enters slot 0 with underrun.
- sck_fall held high for 3 cycles: bcnt advances by 3 and sd/ws follow those slots.
